// File: rtl/accum_ctrl_pkg.sv
// Shared types and field positions for the vector-accumulator start controller.
package accum_ctrl_pkg;

  localparam int CHANNELS  = 512;
  localparam int CHAN_W    = 9;
  localparam int FRAME_W   = 16;

  localparam int START_BIT = 0;
  localparam int CONT_BIT  = 1;
  localparam int NF_LSB    = 16;
  localparam int NF_MSB    = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ACCUM = 2'd2
  } state_e;

  // A frame count of zero is run as a single frame.
  function automatic logic [FRAME_W-1:0] nf_minus_one(input logic [FRAME_W-1:0] nf);
    logic [FRAME_W-1:0] r;
    if (nf == {FRAME_W{1'b0}}) begin
      r = {FRAME_W{1'b0}};
    end else begin
      r = nf - {{(FRAME_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_frame_counter.sv
// Channel/frame position tracker for one integration; restart treats the current beat as
// channel 0 of frame 0, so the counters land on channel 1.
module accum_frame_counter
  import accum_ctrl_pkg::*;
#(
  parameter int CHANNELS_P = CHANNELS,
  parameter int CHAN_W_P   = CHAN_W,
  parameter int FRAME_W_P  = FRAME_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 restart,
  input  logic                 step,
  input  logic [FRAME_W_P-1:0] nf_m1,
  output logic                 chan_zero,
  output logic                 first_frame,
  output logic                 last_frame,
  output logic                 final_beat
);

  localparam logic [CHAN_W_P-1:0] CHAN_MAX = CHAN_W_P'(CHANNELS_P - 1);

  logic [CHAN_W_P-1:0]  chan_q, chan_d;
  logic [FRAME_W_P-1:0] frame_q, frame_d;

  assign chan_zero   = (chan_q == {CHAN_W_P{1'b0}});
  assign first_frame = (frame_q == {FRAME_W_P{1'b0}});
  assign last_frame  = (frame_q == nf_m1);
  assign final_beat  = last_frame && (chan_q == CHAN_MAX);

  always_comb begin
    chan_d  = chan_q;
    frame_d = frame_q;
    if (clear) begin
      chan_d  = {CHAN_W_P{1'b0}};
      frame_d = {FRAME_W_P{1'b0}};
    end else if (restart) begin
      chan_d  = {{(CHAN_W_P-1){1'b0}}, 1'b1};
      frame_d = {FRAME_W_P{1'b0}};
    end else if (step) begin
      if (chan_q == CHAN_MAX) begin
        chan_d  = {CHAN_W_P{1'b0}};
        frame_d = last_frame ? {FRAME_W_P{1'b0}} : frame_q + {{(FRAME_W_P-1){1'b0}}, 1'b1};
      end else begin
        chan_d  = chan_q + {{(CHAN_W_P-1){1'b0}}, 1'b1};
        frame_d = frame_q;
      end
    end else begin
      chan_d  = chan_q;
      frame_d = frame_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_q  <= {CHAN_W_P{1'b0}};
      frame_q <= {FRAME_W_P{1'b0}};
    end else begin
      chan_q  <= chan_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: rtl/accum_start_ctrl.sv
// Turns the startAccumulator register into per-beat load/add/dump control for the
// 512-channel vector accumulator, aligned to the channelizer frame sync.
module accum_start_ctrl
  import accum_ctrl_pkg::*;
(
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] sw_reg,
  input  logic        valid_in,
  input  logic        sync_in,
  output logic        acc_en,
  output logic        acc_first,
  output logic        acc_last,
  output logic        acc_done,
  output logic        busy,
  output logic [31:0] int_count,
  output logic        sync_err
);

  state_e state_q, state_d;
  logic [31:0]        sw_q;
  logic               sw_prev_q;
  logic [FRAME_W-1:0] nf_m1_q, nf_m1_d;
  logic               cont_q, cont_d;
  logic               stop_q, stop_d;
  logic               en_q, en_d, first_q, first_d, last_q, last_d, done_q, done_d;
  logic               busy_q, busy_d, sync_err_q, sync_err_d;
  logic [31:0]        int_count_q, int_count_d;

  logic start_rise, start_fall, sw_unused;
  logic cnt_clear, cnt_restart, cnt_step;
  logic chan_zero, first_frame, last_frame, final_beat;

  assign start_rise = sw_q[START_BIT] & ~sw_prev_q;
  assign start_fall = ~sw_q[START_BIT] & sw_prev_q;
  assign sw_unused  = ^sw_q[NF_LSB-1:CONT_BIT+1];

  accum_frame_counter u_cnt (
    .clk         (user_clk),
    .rst         (user_rst),
    .clear       (cnt_clear),
    .restart     (cnt_restart),
    .step        (cnt_step),
    .nf_m1       (nf_m1_q),
    .chan_zero   (chan_zero),
    .first_frame (first_frame),
    .last_frame  (last_frame),
    .final_beat  (final_beat)
  );

  always_comb begin
    state_d     = state_q;
    nf_m1_d     = nf_m1_q;
    cont_d      = cont_q;
    stop_d      = stop_q;
    en_d        = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    done_d      = 1'b0;
    int_count_d = int_count_q;
    sync_err_d  = sync_err_q;
    cnt_clear   = 1'b0;
    cnt_restart = 1'b0;
    cnt_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d    = ARMED;
          nf_m1_d    = nf_minus_one(sw_q[NF_MSB:NF_LSB]);
          cont_d     = sw_q[CONT_BIT];
          stop_d     = 1'b0;
          sync_err_d = 1'b0;
          cnt_clear  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (valid_in && sync_in) begin
          state_d     = ACCUM;
          cnt_restart = 1'b1;
          en_d        = 1'b1;
          first_d     = 1'b1;
          last_d      = (nf_m1_q == {FRAME_W{1'b0}});
        end else begin
          state_d = ARMED;
        end
      end
      ACCUM: begin
        if (start_fall && cont_q) begin
          stop_d = 1'b1;
        end else begin
          stop_d = stop_q;
        end
        if (valid_in && sync_in && !chan_zero) begin
          // Misaligned sync: drop the partial integration and realign on this beat.
          sync_err_d  = 1'b1;
          cnt_restart = 1'b1;
          en_d        = 1'b1;
          first_d     = 1'b1;
          last_d      = (nf_m1_q == {FRAME_W{1'b0}});
        end else if (valid_in) begin
          cnt_step = 1'b1;
          en_d     = 1'b1;
          first_d  = first_frame;
          last_d   = last_frame;
          if (final_beat) begin
            done_d      = 1'b1;
            int_count_d = int_count_q + 32'd1;
            if (!cont_q || stop_d) begin
              state_d = IDLE;
              stop_d  = 1'b0;
            end else begin
              state_d = ACCUM;
            end
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_clear = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= IDLE;
      sw_q        <= 32'd0;
      sw_prev_q   <= 1'b0;
      nf_m1_q     <= {FRAME_W{1'b0}};
      cont_q      <= 1'b0;
      stop_q      <= 1'b0;
      en_q        <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      sync_err_q  <= 1'b0;
      int_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      sw_q        <= sw_reg;
      sw_prev_q   <= sw_q[START_BIT];
      nf_m1_q     <= nf_m1_d;
      cont_q      <= cont_d;
      stop_q      <= stop_d;
      en_q        <= en_d;
      first_q     <= first_d;
      last_q      <= last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      sync_err_q  <= sync_err_d;
      int_count_q <= int_count_d;
    end
  end

  assign acc_en    = en_q;
  assign acc_first = first_q;
  assign acc_last  = last_q;
  assign acc_done  = done_q;
  assign busy      = busy_q;
  assign sync_err  = sync_err_q;
  assign int_count = int_count_q;

endmodule

// File: tb/tb_accum_start_ctrl.sv
// Directed bench for accum_start_ctrl: output pulses are tallied every cycle and compared
// against hand-computed totals after each scenario.
module tb_accum_start_ctrl;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] sw_reg;
  logic        valid_in, sync_in;
  logic        acc_en, acc_first, acc_last, acc_done, busy, sync_err;
  logic [31:0] int_count;

  int total = 0;
  int bad   = 0;
  int n_en = 0, n_first = 0, n_last = 0, n_both = 0, n_done = 0, n_gap = 0;
  int s_en, s_first, s_last, s_both, s_done, s_gap;
  logic vin_q = 1'b0;

  accum_start_ctrl dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .sw_reg    (sw_reg),
    .valid_in  (valid_in),
    .sync_in   (sync_in),
    .acc_en    (acc_en),
    .acc_first (acc_first),
    .acc_last  (acc_last),
    .acc_done  (acc_done),
    .busy      (busy),
    .int_count (int_count),
    .sync_err  (sync_err)
  );

  always #5 user_clk = ~user_clk;

  // valid_in as seen by the DUT at the last rising edge
  always @(posedge user_clk) vin_q <= valid_in;

  always @(negedge user_clk) begin
    if (acc_en) n_en++;
    if (acc_first) n_first++;
    if (acc_last) n_last++;
    if (acc_first && acc_last) n_both++;
    if (acc_done) n_done++;
    if ((acc_en || acc_first || acc_last) && !vin_q) n_gap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v, input logic s);
    @(negedge user_clk);
    valid_in = v;
    sync_in  = s;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic set_sw(input logic [31:0] v);
    @(negedge user_clk);
    sw_reg   = v;
    valid_in = 1'b0;
    sync_in  = 1'b0;
    idle(3);
  endtask

  task automatic snap();
    s_en = n_en; s_first = n_first; s_last = n_last;
    s_both = n_both; s_done = n_done; s_gap = n_gap;
  endtask

  initial begin
    user_rst = 1'b1;
    sw_reg   = 32'd0;
    valid_in = 1'b0;
    sync_in  = 1'b0;
    idle(2);
    chk("rst_en", {31'd0, acc_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, acc_done}, 32'd0);
    chk("rst_cnt", int_count, 32'd0);
    chk("rst_err", {31'd0, sync_err}, 32'd0);
    @(negedge user_clk);
    user_rst = 1'b0;
    idle(2);

    // 1: two frames, single shot
    snap();
    set_sw(32'h0002_0001);
    chk("t1_busy_armed", {31'd0, busy}, 32'd1);
    tick(1'b1, 1'b1);
    run(1023);
    idle(3);
    chk("t1_en", 32'(n_en - s_en), 32'd1024);
    chk("t1_first", 32'(n_first - s_first), 32'd512);
    chk("t1_last", 32'(n_last - s_last), 32'd512);
    chk("t1_done", 32'(n_done - s_done), 32'd1);
    chk("t1_cnt", int_count, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // 2: n_frames=0 runs as one frame
    set_sw(32'h0000_0000);
    snap();
    set_sw(32'h0000_0001);
    tick(1'b1, 1'b1);
    run(511);
    idle(3);
    chk("t2_en", 32'(n_en - s_en), 32'd512);
    chk("t2_both", 32'(n_both - s_both), 32'd512);
    chk("t2_done", 32'(n_done - s_done), 32'd1);
    chk("t2_cnt", int_count, 32'd2);

    // 3: continuous, three frames, stop during the third integration
    set_sw(32'h0000_0000);
    snap();
    set_sw(32'h0003_0003);
    tick(1'b1, 1'b1);
    run(3071);
    idle(2);
    chk("t3_done2", 32'(n_done - s_done), 32'd2);
    chk("t3_cnt4", int_count, 32'd4);
    chk("t3_busy_run", {31'd0, busy}, 32'd1);
    run(700);
    sw_reg = 32'h0003_0002;
    run(836);
    idle(3);
    chk("t3_done3", 32'(n_done - s_done), 32'd3);
    chk("t3_cnt5", int_count, 32'd5);
    chk("t3_first", 32'(n_first - s_first), 32'd1536);
    chk("t3_last", 32'(n_last - s_last), 32'd1536);
    chk("t3_busy_end", {31'd0, busy}, 32'd0);
    run(10);
    idle(3);
    chk("t3_en_idle", 32'(n_en - s_en), 32'd4608);

    // 4: misaligned sync at channel 100
    set_sw(32'h0000_0000);
    snap();
    set_sw(32'h0002_0001);
    tick(1'b1, 1'b1);
    run(99);
    tick(1'b1, 1'b1);
    run(1023);
    idle(3);
    chk("t4_err", {31'd0, sync_err}, 32'd1);
    chk("t4_en", 32'(n_en - s_en), 32'd1124);
    chk("t4_first", 32'(n_first - s_first), 32'd612);
    chk("t4_last", 32'(n_last - s_last), 32'd512);
    chk("t4_done", 32'(n_done - s_done), 32'd1);
    chk("t4_cnt", int_count, 32'd6);

    // 5: armed without sync, then one frame with valid gaps
    set_sw(32'h0000_0000);
    set_sw(32'h0001_0001);
    chk("t5_err_clr", {31'd0, sync_err}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    snap();
    run(300);
    idle(3);
    chk("t5_no_sync", 32'(n_en - s_en), 32'd0);
    tick(1'b1, 1'b1);
    begin
      int got;
      got = 1;
      for (int i = 0; got < 512; i++) begin
        if ((i % 3) != 2) begin
          tick(1'b1, 1'b0);
          got++;
        end else begin
          tick(1'b0, 1'b0);
        end
      end
    end
    idle(3);
    chk("t5_en", 32'(n_en - s_en), 32'd512);
    chk("t5_both", 32'(n_both - s_both), 32'd512);
    chk("t5_gap", 32'(n_gap - s_gap), 32'd0);
    chk("t5_done", 32'(n_done - s_done), 32'd1);
    chk("t5_cnt", int_count, 32'd7);

    // 6: reset at channel 200 of frame 1, then a clean run
    set_sw(32'h0000_0000);
    set_sw(32'h0002_0001);
    tick(1'b1, 1'b1);
    run(711);
    @(negedge user_clk);
    user_rst = 1'b1;
    sw_reg   = 32'h0000_0000;
    #2;
    chk("t6_en", {31'd0, acc_en}, 32'd0);
    chk("t6_first", {31'd0, acc_first}, 32'd0);
    chk("t6_last", {31'd0, acc_last}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_cnt0", int_count, 32'd0);
    @(negedge user_clk);
    user_rst = 1'b0;
    valid_in = 1'b0;
    idle(2);
    snap();
    set_sw(32'h0002_0001);
    tick(1'b1, 1'b1);
    run(1023);
    idle(3);
    chk("t6_run_en", 32'(n_en - s_en), 32'd1024);
    chk("t6_run_done", 32'(n_done - s_done), 32'd1);
    chk("t6_run_cnt", int_count, 32'd1);
    chk("t6_run_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
